nmr_acq_echo_scheduler: RTL and testbench

//  Sequences a CPMG echo train: per echo period it drives the Q-switch enable,
//  the ADC acquisition window, and the end-of-window pulse. It sits between the

---
 rtl/nmr_acq_echo_scheduler_if.sv | 51 +++++
 rtl/nmr_acq_echo_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_nmr_acq_echo_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nmr_acq_echo_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : nmr_acq_echo_scheduler_if
// Description : Control and timing bundle between the pulse-program
//               controller (master) and the CPMG echo scheduler (slave).
//               Master side drives the train request and timing config.
//               Slave side returns the Q-switch, acquisition-window and
//               status strobes.
// Ports       : START, ABORT              train request / abort strobes
//               NUM_ECHO [EW]             echoes per train
//               ECHO_PER, QSW_LEN,
//               ACQ_DLY, ACQ_LEN [CW]     period timing, in ADC_CLK cycles
//               EN_QSW, ACQ_WND,
//               ACQ_WND_PULSED            per-period timing outputs
//               ECHO_IDX [EW]             current echo index
//               BUSY, DONE, CFG_ERR       train status
// Revision    : 1.0 - initial release
// ============================================================================
interface nmr_acq_echo_scheduler_if #(
  parameter int CW = 16,
  parameter int EW = 12
);
  // controller -> scheduler
  logic          START;
  logic          ABORT;
  logic [EW-1:0] NUM_ECHO;
  logic [CW-1:0] ECHO_PER;
  logic [CW-1:0] QSW_LEN;
  logic [CW-1:0] ACQ_DLY;
  logic [CW-1:0] ACQ_LEN;

  // scheduler -> Q-switch / ADC capture / controller
  logic          EN_QSW;
  logic          ACQ_WND;
  logic          ACQ_WND_PULSED;
  logic [EW-1:0] ECHO_IDX;
  logic          BUSY;
  logic          DONE;
  logic          CFG_ERR;

  modport master (
    output START, ABORT, NUM_ECHO, ECHO_PER, QSW_LEN, ACQ_DLY, ACQ_LEN,
    input  EN_QSW, ACQ_WND, ACQ_WND_PULSED, ECHO_IDX, BUSY, DONE, CFG_ERR
  );

  modport slave (
    input  START, ABORT, NUM_ECHO, ECHO_PER, QSW_LEN, ACQ_DLY, ACQ_LEN,
    output EN_QSW, ACQ_WND, ACQ_WND_PULSED, ECHO_IDX, BUSY, DONE, CFG_ERR
  );
endinterface
`default_nettype wire

// File: rtl/nmr_acq_echo_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : nmr_acq_echo_scheduler
// Description : CPMG echo-train sequencer. For each echo period it drives the
//               Q-switch enable, the ADC acquisition window and a one-cycle
//               end-of-window pulse. Timing config is validated and latched
//               when a train starts, so the host may rewrite it mid-train.
// Ports       : ADC_CLK   sole clock, rising edge
//               RESET_N   asynchronous active-low reset
//               bus       nmr_acq_echo_scheduler_if.slave
//                         (START/ABORT/config in; EN_QSW, ACQ_WND,
//                          ACQ_WND_PULSED, ECHO_IDX, BUSY, DONE, CFG_ERR out)
// Revision    : 1.0 - initial release
// ============================================================================
module nmr_acq_echo_scheduler #(
  parameter int CW = 16,
  parameter int EW = 12
) (
  input  wire logic                ADC_CLK,
  input  wire logic                RESET_N,
  nmr_acq_echo_scheduler_if.slave  bus
);

  // --------------------------------------------------------------------------
  // State encoding. The state register tracks which phase of the period the
  // current PCNT value belongs to; FIN is the single DONE cycle.
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_QSW  = 3'd1,
    S_GAP  = 3'd2,
    S_ACQ  = 3'd3,
    S_TAIL = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t        r_state;

  // latched config (window end is stored pre-summed)
  logic [EW-1:0] r_num_echo;
  logic [CW-1:0] r_echo_per;
  logic [CW-1:0] r_qsw_len;
  logic [CW-1:0] r_acq_dly;
  logic [CW-1:0] r_acq_end;

  // counters
  logic [CW-1:0] r_pcnt;
  logic [EW-1:0] r_echo_idx;

  // registered outputs
  logic          r_en_qsw;
  logic          r_acq_wnd;
  logic          r_acq_pulse;
  logic          r_busy;
  logic          r_done;
  logic          r_cfg_err;

  // --------------------------------------------------------------------------
  // Config validation. The window end is formed one bit wider so that a
  // wrapped ACQ_DLY+ACQ_LEN can never look shorter than the period.
  // --------------------------------------------------------------------------
  logic [CW:0]   w_acq_sum;
  logic          w_cfg_valid;

  assign w_acq_sum   = {1'b0, bus.ACQ_DLY} + {1'b0, bus.ACQ_LEN};
  assign w_cfg_valid = (bus.NUM_ECHO != '0)
                    && (bus.ACQ_LEN != '0)
                    && (bus.QSW_LEN <= bus.ACQ_DLY)
                    && (w_acq_sum < {1'b0, bus.ECHO_PER});

  // --------------------------------------------------------------------------
  // Period / echo bookkeeping
  // --------------------------------------------------------------------------
  logic          w_in_idle;
  logic          w_run;
  logic          w_period_end;
  logic          w_last_echo;

  assign w_in_idle    = (r_state == S_IDLE);
  assign w_run        = (r_state != S_IDLE) && (r_state != S_FIN);
  assign w_period_end = (r_pcnt == (r_echo_per - CW'(1)));
  // compared one bit wider so ECHO_IDX+1 cannot wrap
  assign w_last_echo  = (({1'b0, r_echo_idx} + (EW+1)'(1)) >= {1'b0, r_num_echo});

  // --------------------------------------------------------------------------
  // Next-cycle period position and the outputs it implies. When leaving IDLE
  // the config has not been latched yet, so the live ports are used; the
  // outputs are registered against the PCNT value they describe, which puts
  // the first EN_QSW one cycle after START.
  // --------------------------------------------------------------------------
  logic [CW-1:0] w_cfg_qsw;
  logic [CW-1:0] w_cfg_dly;
  logic [CW-1:0] w_cfg_end;
  logic [CW-1:0] w_pcnt_nxt;
  logic          w_qsw_nxt;
  logic          w_wnd_nxt;
  logic          w_pulse_nxt;
  state_t        w_phase_nxt;

  assign w_cfg_qsw   = w_in_idle ? bus.QSW_LEN           : r_qsw_len;
  assign w_cfg_dly   = w_in_idle ? bus.ACQ_DLY           : r_acq_dly;
  assign w_cfg_end   = w_in_idle ? w_acq_sum[CW-1:0]     : r_acq_end;
  assign w_pcnt_nxt  = (w_in_idle || w_period_end) ? '0  : (r_pcnt + CW'(1));

  assign w_qsw_nxt   = (w_pcnt_nxt <  w_cfg_qsw);
  assign w_wnd_nxt   = (w_pcnt_nxt >= w_cfg_dly) && (w_pcnt_nxt < w_cfg_end);
  // window end is always strictly inside the period, so this always fires
  assign w_pulse_nxt = (w_pcnt_nxt == w_cfg_end);

  // Empty phases fall through naturally: with QSW_LEN=0 position 0 is already
  // GAP (or ACQ when ACQ_DLY=0).
  always_comb begin
    w_phase_nxt = S_TAIL;
    if (w_pcnt_nxt < w_cfg_qsw) begin
      w_phase_nxt = S_QSW;
    end else if (w_pcnt_nxt < w_cfg_dly) begin
      w_phase_nxt = S_GAP;
    end else if (w_pcnt_nxt < w_cfg_end) begin
      w_phase_nxt = S_ACQ;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge ADC_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_num_echo  <= '0;
      r_echo_per  <= '0;
      r_qsw_len   <= '0;
      r_acq_dly   <= '0;
      r_acq_end   <= '0;
      r_pcnt      <= '0;
      r_echo_idx  <= '0;
      r_en_qsw    <= 1'b0;
      r_acq_wnd   <= 1'b0;
      r_acq_pulse <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      // single-cycle strobes
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;

      if (w_run && bus.ABORT) begin
        // abort drops every window at once; the pending end-of-window pulse
        // is suppressed and ECHO_IDX keeps the echo that was interrupted
        r_state     <= S_FIN;
        r_en_qsw    <= 1'b0;
        r_acq_wnd   <= 1'b0;
        r_acq_pulse <= 1'b0;
        r_busy      <= 1'b0;
        r_done      <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            // ABORT coincident with START drops the request
            if (bus.START && !bus.ABORT) begin
              if (w_cfg_valid) begin
                r_num_echo  <= bus.NUM_ECHO;
                r_echo_per  <= bus.ECHO_PER;
                r_qsw_len   <= bus.QSW_LEN;
                r_acq_dly   <= bus.ACQ_DLY;
                r_acq_end   <= w_acq_sum[CW-1:0];
                r_pcnt      <= '0;
                r_echo_idx  <= '0;
                r_busy      <= 1'b1;
                r_en_qsw    <= w_qsw_nxt;
                r_acq_wnd   <= w_wnd_nxt;
                r_acq_pulse <= w_pulse_nxt;
                r_state     <= w_phase_nxt;
              end else begin
                r_cfg_err   <= 1'b1;
              end
            end
          end

          S_FIN: begin
            r_state <= S_IDLE;
          end

          default: begin
            if (w_period_end && w_last_echo) begin
              r_state     <= S_FIN;
              r_en_qsw    <= 1'b0;
              r_acq_wnd   <= 1'b0;
              r_acq_pulse <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              // back-to-back periods: PCNT wraps with no idle gap
              if (w_period_end) begin
                r_echo_idx <= r_echo_idx + EW'(1);
              end
              r_pcnt      <= w_pcnt_nxt;
              r_en_qsw    <= w_qsw_nxt;
              r_acq_wnd   <= w_wnd_nxt;
              r_acq_pulse <= w_pulse_nxt;
              r_state     <= w_phase_nxt;
            end
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign bus.EN_QSW         = r_en_qsw;
  assign bus.ACQ_WND        = r_acq_wnd;
  assign bus.ACQ_WND_PULSED = r_acq_pulse;
  assign bus.ECHO_IDX       = r_echo_idx;
  assign bus.BUSY           = r_busy;
  assign bus.DONE           = r_done;
  assign bus.CFG_ERR        = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_nmr_acq_echo_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_nmr_acq_echo_scheduler
// Description : Self-checking bench for nmr_acq_echo_scheduler. Expected
//               outputs come from a cycle-offset model: for offset t after a
//               START, PCNT = t mod ECHO_PER and ECHO_IDX = t div ECHO_PER.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nmr_acq_echo_scheduler;

  localparam int CW = 16;
  localparam int EW = 12;
  localparam int VW = EW + 6;

  // {EN_QSW, ACQ_WND, ACQ_WND_PULSED, BUSY, DONE, CFG_ERR, ECHO_IDX}
  typedef logic [VW-1:0] vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   last_idx;

  nmr_acq_echo_scheduler_if #(.CW(CW), .EW(EW)) bus ();

  nmr_acq_echo_scheduler #(.CW(CW), .EW(EW)) dut (
    .ADC_CLK (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model and stimulus helpers ----------------
  function automatic vec_t model_vec(int t, int num, int per, int qsw, int dly, int len);
    int p;
    int e;
    vec_t v;
    if (t < num * per) begin
      p = t % per;
      e = t / per;
      v = {p < qsw, (p >= dly) && (p < dly + len), p == dly + len,
           1'b1, 1'b0, 1'b0, EW'(e)};
    end else begin
      v = {1'b0, 1'b0, 1'b0, 1'b0, (t == num * per), 1'b0, EW'(num - 1)};
    end
    return v;
  endfunction

  function automatic vec_t idle_vec(int idx, logic cfg_err);
    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cfg_err, EW'(idx)};
  endfunction

  function automatic vec_t obs_vec();
    return {bus.EN_QSW, bus.ACQ_WND, bus.ACQ_WND_PULSED, bus.BUSY,
            bus.DONE, bus.CFG_ERR, bus.ECHO_IDX};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(int num, int per, int qsw, int dly, int len);
    bus.NUM_ECHO = EW'(num);
    bus.ECHO_PER = CW'(per);
    bus.QSW_LEN  = CW'(qsw);
    bus.ACQ_DLY  = CW'(dly);
    bus.ACQ_LEN  = CW'(len);
  endtask

  task automatic rand_cfg(output int num, output int per, output int qsw,
                          output int dly, output int len);
    per = int'($urandom_range(2, 30));
    dly = int'($urandom_range(0, per - 2));
    len = int'($urandom_range(1, per - 1 - dly));
    qsw = int'($urandom_range(0, dly));
    num = int'($urandom_range(1, 4));
  endtask

  // START is applied here and taken on the following edge; on return the
  // outputs describe offset t=0 of the train.
  task automatic pulse_start();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    vec_t o;
    o = obs_vec();
    checks++;
    if (o !== idle_vec(0, 1'b0)) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", o, idle_vec(0, 1'b0));
    end
  endtask

  task automatic test_cfg_err();
    int cfg [5][5] = '{
      '{3, 20, 4, 6, 14},          // window end equals period
      '{3, 20, 5, 4, 8},           // Q-switch overlaps window start
      '{0, 20, 4, 6, 8},           // no echoes
      '{3, 65535, 0, 65535, 65535},// sum overflows CW bits
      '{3, 20, 4, 6, 0}            // empty window
    };
    vec_t o;
    for (int i = 0; i < 5; i++) begin
      set_cfg(cfg[i][0], cfg[i][1], cfg[i][2], cfg[i][3], cfg[i][4]);
      pulse_start();
      o = obs_vec();
      checks++;
      if (o !== idle_vec(last_idx, 1'b1)) begin
        failures++;
        $display("FAIL cfg_err_pulse case=%0d got=%h exp=%h", i, o, idle_vec(last_idx, 1'b1));
      end
      step();
      o = obs_vec();
      checks++;
      if (o !== idle_vec(last_idx, 1'b0)) begin
        failures++;
        $display("FAIL cfg_err_clear case=%0d got=%h exp=%h", i, o, idle_vec(last_idx, 1'b0));
      end
    end
  endtask

  task automatic test_basic_train();
    vec_t o;
    vec_t e;
    set_cfg(3, 20, 4, 6, 8);
    pulse_start();
    for (int t = 0; t <= 3 * 20 + 1; t++) begin
      o = obs_vec();
      e = model_vec(t, 3, 20, 4, 6, 8);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL basic_train t=%0d got=%h exp=%h", t, o, e);
      end
      step();
    end
    last_idx = 2;
  endtask

  task automatic test_min_period();
    vec_t o;
    vec_t e;
    set_cfg(4, 2, 0, 0, 1);
    pulse_start();
    for (int t = 0; t <= 4 * 2 + 1; t++) begin
      o = obs_vec();
      e = model_vec(t, 4, 2, 0, 0, 1);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL min_period t=%0d got=%h exp=%h", t, o, e);
      end
      step();
    end
    last_idx = 3;
  endtask

  task automatic test_abort();
    vec_t o;
    vec_t e;
    int   num, per, qsw, dly, len;
    int   t_abort;
    set_cfg(3, 20, 4, 6, 8);
    pulse_start();
    t_abort = 20 + 6 + 2;  // inside ACQ of echo 1
    for (int t = 0; t <= t_abort; t++) begin
      o = obs_vec();
      e = model_vec(t, 3, 20, 4, 6, 8);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL abort_pre t=%0d got=%h exp=%h", t, o, e);
      end
      if (t == t_abort) bus.ABORT = 1'b1;
      else step();
    end
    step();
    bus.ABORT = 1'b0;
    o = obs_vec();
    e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, EW'(1)};
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL abort_done got=%h exp=%h", o, e);
    end
    step();
    o = obs_vec();
    checks++;
    if (o !== idle_vec(1, 1'b0)) begin
      failures++;
      $display("FAIL abort_after got=%h exp=%h", o, idle_vec(1, 1'b0));
    end
    // restart one cycle after DONE
    rand_cfg(num, per, qsw, dly, len);
    set_cfg(num, per, qsw, dly, len);
    pulse_start();
    for (int t = 0; t <= num * per + 1; t++) begin
      o = obs_vec();
      e = model_vec(t, num, per, qsw, dly, len);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL abort_restart t=%0d got=%h exp=%h", t, o, e);
      end
      step();
    end
    last_idx = num - 1;
    // ABORT with START in IDLE: nothing happens
    bus.ABORT = 1'b1;
    pulse_start();
    bus.ABORT = 1'b0;
    o = obs_vec();
    checks++;
    if (o !== idle_vec(last_idx, 1'b0)) begin
      failures++;
      $display("FAIL abort_start_idle got=%h exp=%h", o, idle_vec(last_idx, 1'b0));
    end
    step();
    o = obs_vec();
    checks++;
    if (o !== idle_vec(last_idx, 1'b0)) begin
      failures++;
      $display("FAIL abort_start_idle2 got=%h exp=%h", o, idle_vec(last_idx, 1'b0));
    end
  endtask

  task automatic test_busy_restart();
    vec_t o;
    vec_t e;
    int   num, per, qsw, dly, len;
    int   t_restart;
    rand_cfg(num, per, qsw, dly, len);
    if (num < 2) num = 2;
    set_cfg(num, per, qsw, dly, len);
    pulse_start();
    t_restart = int'($urandom_range(1, num * per - 2));
    for (int t = 0; t <= num * per + 1; t++) begin
      o = obs_vec();
      e = model_vec(t, num, per, qsw, dly, len);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL busy_restart t=%0d got=%h exp=%h", t, o, e);
      end
      // rewrite the config ports every cycle with arbitrary values
      set_cfg(int'($urandom_range(0, 20)), int'($urandom_range(0, 40)),
              int'($urandom_range(0, 10)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 20)));
      bus.START = (t == t_restart);
      step();
    end
    bus.START = 1'b0;
    last_idx = num - 1;
  endtask

  task automatic test_random_trains();
    vec_t o;
    vec_t e;
    int   num, per, qsw, dly, len;
    for (int k = 0; k < 6; k++) begin
      rand_cfg(num, per, qsw, dly, len);
      set_cfg(num, per, qsw, dly, len);
      pulse_start();
      for (int t = 0; t <= num * per + 1; t++) begin
        o = obs_vec();
        e = model_vec(t, num, per, qsw, dly, len);
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL random_train k=%0d t=%0d got=%h exp=%h", k, t, o, e);
        end
        step();
      end
      last_idx = num - 1;
    end
  endtask

  task automatic test_async_reset();
    vec_t o;
    vec_t e;
    set_cfg(3, 20, 4, 6, 8);
    pulse_start();
    for (int t = 0; t < 20 + 6 + 3; t++) step();
    // mid-ACQ of echo 1; check we are where we think
    o = obs_vec();
    e = model_vec(20 + 6 + 3, 3, 20, 4, 6, 8);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL async_pre got=%h exp=%h", o, e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    o = obs_vec();
    checks++;
    if (o !== idle_vec(0, 1'b0)) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", o, idle_vec(0, 1'b0));
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      o = obs_vec();
      checks++;
      if (o !== idle_vec(0, 1'b0)) begin
        failures++;
        $display("FAIL async_idle i=%0d got=%h exp=%h", i, o, idle_vec(0, 1'b0));
      end
    end
    set_cfg(2, 5, 1, 2, 2);
    pulse_start();
    for (int t = 0; t <= 2 * 5 + 1; t++) begin
      o = obs_vec();
      e = model_vec(t, 2, 5, 1, 2, 2);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL async_restart t=%0d got=%h exp=%h", t, o, e);
      end
      step();
    end
    last_idx = 1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    last_idx  = 0;
    rst_n     = 1'b0;
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();

    test_reset();
    test_cfg_err();
    test_basic_train();
    test_min_period();
    test_abort();
    test_busy_restart();
    test_random_trains();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
